// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared types and constants for the Pong score / BCD display slice.
//   winner_t      : encoding of the winner flag (bit0 = left, bit1 = right)
//   conv_state_t  : states of the binary-to-BCD conversion sequencer
//   SCORE_MAX     : saturation value of each score register
//   BCD_W         : width of the two-digit BCD accumulator
//   add3_adjust() : the double-dabble correction step applied before a shift
// -----------------------------------------------------------------------------
package score_pkg;

    localparam int SCORE_MAX = 99;
    localparam int BCD_W     = 8;

    // Bit 0 flags the left player and bit 1 the right player, so a tie is
    // simply both bits set.
    typedef enum logic [1:0] {
        NONE  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10,
        TIE   = 2'b11
    } winner_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD   = 2'b01,
        SHIFT  = 2'b10,
        COMMIT = 2'b11
    } conv_state_t;

    // Every BCD nibble that is 5 or more gets +3, so that the following
    // left shift carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/bcd_double_dabble.sv
// -----------------------------------------------------------------------------
// bcd_double_dabble
// Sequential shift/add-3 binary-to-BCD engine. The parent sequencer decides
// when to load and when to shift; after SCORE_W shifts bcd_out holds the
// two BCD digits of the loaded value.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   load      : capture bin_in and clear the BCD accumulator
//   shift_en  : perform one add-3 / shift-left step
//   bin_in    : binary value to convert (SCORE_W bits)
//   bcd_out   : {tens, ones} BCD accumulator
// -----------------------------------------------------------------------------
module bcd_double_dabble
    import score_pkg::*;
#(
    parameter int SCORE_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift_en,
    input  logic [SCORE_W-1:0] bin_in,
    output logic [BCD_W-1:0]   bcd_out
);

    logic [SCORE_W-1:0] bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_adj;

    assign bcd_adj = add3_adjust(bcd_q);

    // NOTE: the engine registers are plain flops, not a memory array, so they
    // take the asynchronous reset like every other piece of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
        end else if (load) begin
            bin_q <= bin_in;
            bcd_q <= '0;
        end else if (shift_en) begin
            // {bcd, bin} shifts left as one register: the binary MSB enters
            // the BCD LSB.
            bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
            bin_q <= {bin_q[SCORE_W-2:0], 1'b0};
        end
    end

    assign bcd_out = bcd_q;

endmodule

// File: rtl/score_bcd_display.sv
// -----------------------------------------------------------------------------
// score_bcd_display
// Holds both Pong scores (saturating at 99), flags the winner, and converts
// each score to two BCD digits for the downstream 7-segment decoders using
// two double-dabble engines driven by one shared sequencer.
// Ports:
//   Clk, Reset              : clock (rising edge), async active-high reset
//   game_reset              : synchronous clear for a new game
//   point_left/point_right  : single-cycle point pulses
//   score_left/score_right  : binary scores
//   left_tens..right_ones   : committed BCD digits (registered)
//   winner                  : 00 none, 01 left, 10 right, 11 tie
//   busy                    : a conversion is pending or running
// Timing: a point at edge k enters LOAD at k+1 (engines loaded on that edge),
// shifts on edges k+2..k+1+SCORE_W, and the digits commit at k+SCORE_W+2.
// -----------------------------------------------------------------------------
module score_bcd_display
    import score_pkg::*;
#(
    parameter int SCORE_W   = 7,
    parameter int WIN_SCORE = 11
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               game_reset,
    input  logic               point_left,
    input  logic               point_right,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [3:0]         left_tens,
    output logic [3:0]         left_ones,
    output logic [3:0]         right_tens,
    output logic [3:0]         right_ones,
    output logic [1:0]         winner,
    output logic               busy
);

    localparam int                 CNT_W   = $clog2(SCORE_W + 1);
    localparam logic [SCORE_W-1:0] MAX_S   = SCORE_W'(SCORE_MAX);
    localparam logic [SCORE_W:0]   MAX_EXT = (SCORE_W + 1)'(SCORE_MAX);
    localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   LAST_SH = CNT_W'(SCORE_W - 1);

    conv_state_t        state;
    winner_t            winner_q, winner_d;
    logic               pending, pending_d;
    logic [CNT_W-1:0]   shift_cnt;
    logic               inc_left, inc_right;
    logic               left_won, right_won;
    logic [SCORE_W:0]   sum_left, sum_right;
    logic [SCORE_W-1:0] next_left, next_right;
    logic               load, shift_en;
    logic [BCD_W-1:0]   bcd_left, bcd_right;

    // Next scores, winner and pending flag.
    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        inc_left   = point_left  && (winner_q == NONE) && (score_left  != MAX_S);
        inc_right  = point_right && (winner_q == NONE) && (score_right != MAX_S);
        sum_left   = {1'b0, score_left}  + (SCORE_W + 1)'(1);
        sum_right  = {1'b0, score_right} + (SCORE_W + 1)'(1);
        next_left  = score_left;
        next_right = score_right;
        if (inc_left) begin
            next_left = (sum_left > MAX_EXT) ? MAX_S : sum_left[SCORE_W-1:0];
        end
        if (inc_right) begin
            next_right = (sum_right > MAX_EXT) ? MAX_S : sum_right[SCORE_W-1:0];
        end

        left_won  = next_left  >= WIN_S;
        right_won = next_right >= WIN_S;
        winner_d  = winner_q;
        if (winner_q == NONE) begin
            // The encoding is {right, left}, so both reaching it gives TIE.
            winner_d = winner_t'({right_won, left_won});
        end

        // Leaving IDLE consumes the pending request; a point in the same
        // cycle re-arms it, so no update is lost.
        pending_d = inc_left | inc_right | (pending & (state != IDLE));
    end

    assign load     = (state == IDLE) && pending && !game_reset;
    assign shift_en = ((state == LOAD) || (state == SHIFT)) && !game_reset;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            score_left  <= '0;
            score_right <= '0;
            winner_q    <= NONE;
            pending     <= 1'b0;
            state       <= IDLE;
            shift_cnt   <= '0;
            left_tens   <= '0;
            left_ones   <= '0;
            right_tens  <= '0;
            right_ones  <= '0;
        end else if (game_reset) begin
            score_left  <= '0;
            score_right <= '0;
            winner_q    <= NONE;
            pending     <= 1'b0;
            state       <= IDLE;
            shift_cnt   <= '0;
            left_tens   <= '0;
            left_ones   <= '0;
            right_tens  <= '0;
            right_ones  <= '0;
        end else begin
            score_left  <= next_left;
            score_right <= next_right;
            winner_q    <= winner_d;
            pending     <= pending_d;
            case (state)
                IDLE: begin
                    if (pending) begin
                        state <= LOAD;
                    end
                end
                // The engines were loaded on the edge into LOAD; this edge
                // performs the first of SCORE_W shifts.
                LOAD: begin
                    state     <= SHIFT;
                    shift_cnt <= CNT_W'(1);
                end
                SHIFT: begin
                    if (shift_cnt == LAST_SH) begin
                        state <= COMMIT;
                    end else begin
                        shift_cnt <= shift_cnt + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    // All four digits change on one edge.
                    left_tens  <= bcd_left[7:4];
                    left_ones  <= bcd_left[3:0];
                    right_tens <= bcd_right[7:4];
                    right_ones <= bcd_right[3:0];
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign winner = winner_q;
    assign busy   = pending | (state != IDLE);

    bcd_double_dabble #(.SCORE_W(SCORE_W)) u_left (
        .clk      (Clk),
        .rst      (Reset),
        .load     (load),
        .shift_en (shift_en),
        .bin_in   (score_left),
        .bcd_out  (bcd_left)
    );

    bcd_double_dabble #(.SCORE_W(SCORE_W)) u_right (
        .clk      (Clk),
        .rst      (Reset),
        .load     (load),
        .shift_en (shift_en),
        .bin_in   (score_right),
        .bcd_out  (bcd_right)
    );

endmodule

// File: doc/score_bcd_display.md
Name: score_bcd_display

Overview:
Holds both Pong players' scores and converts each score to two BCD digits with a sequential double-dabble engine. Also flags the winner. Sits directly upstream of the four hex-digit 7-segment decoders: its four nibble outputs drive their 4-bit inputs. Point pulses arrive from the ball/collision logic.

Parameters:
SCORE_W, 7, width of each score register; scores saturate at 99.
WIN_SCORE, 11, score at which a player wins; legal range 1..99.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-high; clears all state.
game_reset  input  1  synchronous clear of scores, winner and digits for a new game.
point_left  input  1  single-cycle pulse: left player scored.
point_right  input  1  single-cycle pulse: right player scored.
score_left  output  SCORE_W  current left score, binary.
score_right  output  SCORE_W  current right score, binary.
left_tens  output  4  BCD tens digit of the left score.
left_ones  output  4  BCD ones digit of the left score.
right_tens  output  4  BCD tens digit of the right score.
right_ones  output  4  BCD ones digit of the right score.
winner  output  2  00 none, 01 left, 10 right, 11 tie.
busy  output  1  high while a conversion is pending or running.

Behaviour:
- Reset (async): scores=0, digits=0, winner=00, busy=0, FSM=IDLE, pending=0.
- Scoring:
  - point_x sampled at edge k: score_x increments at edge k (visible after k); pending set at edge k.
  - The increment is ignored if winner!=00 or score_x==99; in that case pending is not set.
  - Both pulses in the same cycle: both scores increment.
- Winner:
  - Updated combinationally from the registered scores and registered at the same edge as the score.
  - Any score reaching WIN_SCORE with winner==00 sets winner: 01 or 10; 11 if both reach it in the same cycle.
  - winner holds until game_reset or Reset.
- Conversion FSM: IDLE -> LOAD -> SHIFT -> COMMIT -> IDLE.
  - IDLE: go to LOAD if pending.
  - LOAD: capture both scores into the engines; clear pending.
  - SHIFT: exactly SCORE_W cycles. Each cycle, every BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1.
  - COMMIT: copy all four nibbles to the outputs in one edge, so the outputs never show a half-updated score.
- Latency: pulse at edge k -> LOAD at k+1, shifts k+2..k+8, digits valid after edge k+9 (SCORE_W+2 cycles after the score update).
- busy = pending | (FSM!=IDLE).
- A point arriving during LOAD/SHIFT/COMMIT sets pending. Exactly one further conversion follows COMMIT; no update is ever lost.
- game_reset:
  - Has priority over point pulses in the same cycle.
  - Clears scores, winner, digits, pending and returns the FSM to IDLE at that edge, aborting any conversion in flight.
- Width rules:
  - BCD accumulator is 8 bits; the tens digit never exceeds 9 because of saturation.
  - The increment is done at SCORE_W+1 bits and compared against 99 before write-back.
- Outputs are registered; no combinational path from the inputs to the digits.

Decomposition:
- Shared package score_pkg:
  - typedef winner_t (enum NONE, LEFT, RIGHT, TIE)
  - typedef conv_state_t (IDLE, LOAD, SHIFT, COMMIT)
  - constant SCORE_MAX=99
  - constant BCD_W=8
- Sub-module bcd_double_dabble:
  - One sequential shift/add-3 engine with load, shift_en, bin_in[SCORE_W-1:0], bcd_out[7:0].
  - Instantiated twice (left and right), sharing the parent's FSM and shift counter.

Test Plan:
- Reset mid-conversion: assert Reset at SHIFT cycle 3 -> all outputs 0, busy=0 immediately (asynchronous).
- Single point: point_left pulse -> score_left=1 next cycle; busy=1; left_tens=0, left_ones=1 exactly 9 cycles after the score update; busy=0 afterwards.
- Simultaneous points to winner: 11 pulses with both point_left and point_right high together -> scores 11/11, winner=11, digits 1,1,1,1. A 12th pulse leaves scores at 11.
- Pending during conversion: point_right at SHIFT cycle 2 of a prior conversion -> second conversion runs; final right digits match the final score; busy stays high across both conversions.
- Saturation: WIN_SCORE=99 override, 105 left pulses -> score_left=99, digits 9,9, winner=01.
- game_reset together with point_left: scores 5/3 -> scores 0/0, digits 0, winner=00, no conversion started (busy=0).
